// File: rtl/updown_sweep_ctrl_if.sv
// rtl/updown_sweep_ctrl_if.sv - counter-side signal bundle between the sweep sequencer and the up/down counter
interface updown_sweep_ctrl_if #(
    parameter int WIDTH = 3
);
    logic             cnt_en;
    logic             cnt_mode;
    logic             cnt_ld;
    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] cnt_q;

    modport master (output cnt_en, cnt_mode, cnt_ld, cnt_d, input cnt_q);
    modport slave  (input cnt_en, cnt_mode, cnt_ld, cnt_d, output cnt_q);
endinterface

// File: rtl/updown_sweep_ctrl.sv
// rtl/updown_sweep_ctrl.sv - ping-pong sweep sequencer for an up/down counter
// Optional hold input enabled by defining SWEEP_CTRL_HOLD_EN.
module updown_sweep_ctrl #(
    parameter int WIDTH = 3,
    parameter int DWELL = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
`ifdef SWEEP_CTRL_HOLD_EN
    input  logic                hold,
`endif
    input  logic [WIDTH-1:0]    lo,
    input  logic [WIDTH-1:0]    hi,
    input  logic [7:0]          n_sweeps,
    updown_sweep_ctrl_if.master cnt,
    output logic                busy,
    output logic                done,
    output logic                aborted,
    output logic                err,
    output logic [7:0]          sweeps
);
    localparam int DCW = (DWELL > 1) ? $clog2(DWELL) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_UP,
        S_DWELL_HI,
        S_DOWN,
        S_DWELL_LO
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] lo_r;
    logic [WIDTH-1:0] hi_r;
    logic [7:0]       n_r;
    logic [DCW-1:0]   dwell_cnt;
    logic             mode_r;
    logic             ld_r;
    logic             hold_w;
    logic             cnt_en_w;
    logic             dwell_last;
    logic [7:0]       sweeps_inc;

`ifdef SWEEP_CTRL_HOLD_EN
    assign hold_w = hold;
`else
    assign hold_w = 1'b0;
`endif

    assign dwell_last = (dwell_cnt == DCW'(DWELL - 1));
    assign sweeps_inc = sweeps + 8'd1;

    // Gating with stop keeps the counter frozen on the abort edge itself.
    always_comb begin
        cnt_en_w = 1'b0;
        if (!stop && !hold_w) begin
            if (state == S_UP)
                cnt_en_w = (cnt.cnt_q < hi_r);
            else if (state == S_DOWN)
                cnt_en_w = (cnt.cnt_q > lo_r);
        end
    end

    assign cnt.cnt_en   = cnt_en_w;
    assign cnt.cnt_mode = mode_r;
    assign cnt.cnt_ld   = ld_r;
    assign cnt.cnt_d    = lo_r;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            lo_r      <= '0;
            hi_r      <= '0;
            n_r       <= '0;
            dwell_cnt <= '0;
            mode_r    <= 1'b0;
            ld_r      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
            err       <= 1'b0;
            sweeps    <= '0;
        end else begin
            done    <= 1'b0;
            aborted <= 1'b0;
            err     <= 1'b0;
            ld_r    <= 1'b0;
            if (state != S_IDLE && stop) begin
                state   <= S_IDLE;
                busy    <= 1'b0;
                mode_r  <= 1'b0;
                aborted <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start && !stop) begin
                            if (lo < hi) begin
                                lo_r   <= lo;
                                hi_r   <= hi;
                                n_r    <= n_sweeps;
                                sweeps <= '0;
                                ld_r   <= 1'b1;
                                busy   <= 1'b1;
                                state  <= S_LOAD;
                            end else begin
                                err <= 1'b1;
                            end
                        end
                    end
                    S_LOAD: state <= S_UP;
                    S_UP: begin
                        if (!hold_w && cnt.cnt_q >= hi_r) begin
                            dwell_cnt <= '0;
                            state     <= S_DWELL_HI;
                        end
                    end
                    S_DWELL_HI: begin
                        if (!hold_w) begin
                            if (dwell_last) begin
                                mode_r <= 1'b1;
                                state  <= S_DOWN;
                            end else begin
                                dwell_cnt <= dwell_cnt + 1'b1;
                            end
                        end
                    end
                    S_DOWN: begin
                        if (!hold_w && cnt.cnt_q <= lo_r) begin
                            mode_r    <= 1'b0;
                            dwell_cnt <= '0;
                            state     <= S_DWELL_LO;
                        end
                    end
                    S_DWELL_LO: begin
                        if (!hold_w) begin
                            if (dwell_last) begin
                                sweeps <= sweeps_inc;
                                if (n_r != 8'd0 && sweeps_inc == n_r) begin
                                    busy  <= 1'b0;
                                    done  <= 1'b1;
                                    state <= S_IDLE;
                                end else begin
                                    state <= S_UP;
                                end
                            end else begin
                                dwell_cnt <= dwell_cnt + 1'b1;
                            end
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// tb/tb_updown_sweep_ctrl.sv - self-checking bench for updown_sweep_ctrl with a behavioural counter
module tb_updown_sweep_ctrl;
    localparam int WIDTH    = 3;
    localparam int DWELL    = 2;
    localparam int HOLD_LEN = 4;

    logic       clk;
    logic       reset;
    logic       start;
    logic       stop;
    logic       hold;
    logic [2:0] lo;
    logic [2:0] hi;
    logic [7:0] n_sweeps;
    logic       busy;
    logic       done;
    logic       aborted;
    logic       err;
    logic [7:0] sweeps;
    int         errors;
    int         checks;

    updown_sweep_ctrl_if #(.WIDTH(WIDTH)) cif ();

    updown_sweep_ctrl #(.WIDTH(WIDTH), .DWELL(DWELL)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .stop     (stop),
`ifdef SWEEP_CTRL_HOLD_EN
        .hold     (hold),
`endif
        .lo       (lo),
        .hi       (hi),
        .n_sweeps (n_sweeps),
        .cnt      (cif.master),
        .busy     (busy),
        .done     (done),
        .aborted  (aborted),
        .err      (err),
        .sweeps   (sweeps)
    );

    // Loadable, enable-gated up/down counter closing the loop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cif.cnt_q <= '0;
        else if (cif.cnt_ld)
            cif.cnt_q <= cif.cnt_d;
        else if (cif.cnt_en)
            cif.cnt_q <= cif.cnt_mode ? cif.cnt_q - 1'b1 : cif.cnt_q + 1'b1;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, aborted, err, cif.cnt_en, cif.cnt_mode, cif.cnt_ld} !== 7'b0) begin
            errors++;
            $display("FAIL reset_flags got=%b exp=0000000",
                     {busy, done, aborted, err, cif.cnt_en, cif.cnt_mode, cif.cnt_ld});
        end
        checks++;
        if ({cif.cnt_d, sweeps} !== 11'd0) begin
            errors++;
            $display("FAIL reset_values cnt_d=%0d sweeps=%0d exp=0", cif.cnt_d, sweeps);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Expected cnt_q trace from phase rules: lo..hi, dwell at hi, hi..lo, dwell at lo.
    task automatic run_sweep(input int l, input int h, input int n, input int hold_at,
                             input bit scramble, input string tag);
        logic [2:0] expq[$];
        int         s_len;
        int         t_end;
        int         toggles;
        logic       prev_mode;
        s_len = 2 * (h - l + 1) + 2 * DWELL;
        for (int k = 0; k < n; k++) begin
            for (int v = l; v <= h; v++) expq.push_back(3'(v));
            repeat (DWELL) expq.push_back(3'(h));
            for (int v = h; v >= l; v--) expq.push_back(3'(v));
            repeat (DWELL) expq.push_back(3'(l));
        end
        t_end = 2 + n * s_len;
        if (hold_at != 0) begin
            t_end = t_end + HOLD_LEN;
            for (int j = 0; j < HOLD_LEN; j++) expq.insert(hold_at - 2, expq[hold_at - 2]);
        end
        lo = 3'(l); hi = 3'(h); n_sweeps = 8'(n); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if ({cif.cnt_ld, busy} !== 2'b11 || cif.cnt_d !== 3'(l)) begin
            errors++;
            $display("FAIL %s load cnt_ld=%b busy=%b cnt_d=%0d exp 1 1 %0d", tag, cif.cnt_ld, busy, cif.cnt_d, l);
        end
        if (scramble) begin
            lo = 3'($urandom); hi = 3'($urandom); n_sweeps = 8'($urandom);
        end
        prev_mode = cif.cnt_mode;
        toggles   = 0;
        for (int c = 2; c <= t_end; c++) begin
            @(negedge clk);
            if (cif.cnt_mode !== prev_mode) toggles++;
            prev_mode = cif.cnt_mode;
            if (c < t_end) begin
                checks++;
                if (cif.cnt_q !== expq[c - 2] || done !== 1'b0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s cycle %0d cnt_q=%0d done=%b busy=%b exp %0d 0 1",
                             tag, c, cif.cnt_q, done, busy, expq[c - 2]);
                end
            end
            if (hold_at != 0 && c == hold_at) hold = 1'b1;
            if (hold_at != 0 && c == hold_at + HOLD_LEN) hold = 1'b0;
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || sweeps !== 8'(n)) begin
            errors++;
            $display("FAIL %s end done=%b busy=%b sweeps=%0d exp 1 0 %0d", tag, done, busy, sweeps, n);
        end
        checks++;
        if (toggles !== 2 * n) begin
            errors++;
            $display("FAIL %s mode_toggles got=%0d exp=%0d", tag, toggles, 2 * n);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s post done=%b busy=%b exp 0 0", tag, done, busy);
        end
    endtask

    task automatic test_single();
        run_sweep(1, 5, 1, 0, 1'b0, "single");
    endtask

    task automatic test_multi();
        run_sweep(0, 7, 3, 0, 1'b0, "multi");
    endtask

    task automatic test_random();
        int l;
        int h;
        for (int i = 0; i < 5; i++) begin
            l = $urandom_range(0, 6);
            h = $urandom_range(l + 1, 7);
            run_sweep(l, h, $urandom_range(1, 3), 0, 1'b1, "random");
        end
    endtask

    task automatic test_reject();
        int pairs[2][2] = '{'{4, 4}, '{6, 2}};
        for (int i = 0; i < 2; i++) begin
            lo = 3'(pairs[i][0]); hi = 3'(pairs[i][1]); n_sweeps = 8'd1; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            checks++;
            if ({err, busy, cif.cnt_ld} !== 3'b100) begin
                errors++;
                $display("FAIL reject_%0d err/busy/ld got=%b exp=100", i, {err, busy, cif.cnt_ld});
            end
            @(negedge clk);
            checks++;
            if ({err, busy, cif.cnt_ld} !== 3'b000) begin
                errors++;
                $display("FAIL reject_after_%0d err/busy/ld got=%b exp=000", i, {err, busy, cif.cnt_ld});
            end
        end
    endtask

    task automatic test_abort();
        bit found;
        lo = 3'd0; hi = 3'd7; n_sweeps = 8'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (cif.cnt_mode === 1'b1 && cif.cnt_q === 3'd3) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL abort_reach got=0 exp=1 (DOWN at cnt_q=3 not seen)");
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        checks++;
        if ({busy, aborted, cif.cnt_en, done} !== 4'b0100 || cif.cnt_q !== 3'd3 || sweeps !== 8'd0) begin
            errors++;
            $display("FAIL abort busy/aborted/en/done=%b cnt_q=%0d sweeps=%0d exp 0100 3 0",
                     {busy, aborted, cif.cnt_en, done}, cif.cnt_q, sweeps);
        end
        @(negedge clk);
        checks++;
        if ({aborted, done} !== 2'b00 || cif.cnt_q !== 3'd3) begin
            errors++;
            $display("FAIL abort_after aborted/done=%b cnt_q=%0d exp 00 3", {aborted, done}, cif.cnt_q);
        end
        for (int i = 0; i < 2; i++) begin
            lo = (i == 0) ? 3'd1 : 3'd5; hi = (i == 0) ? 3'd5 : 3'd1;
            start = 1'b1; stop = 1'b1;
            @(negedge clk);
            start = 1'b0; stop = 1'b0;
            @(negedge clk);
            checks++;
            if ({busy, cif.cnt_ld, err, aborted, done} !== 5'b0) begin
                errors++;
                $display("FAIL start_stop_%0d busy/ld/err/aborted/done=%b exp=00000",
                         i, {busy, cif.cnt_ld, err, aborted, done});
            end
        end
    endtask

    task automatic test_async_reset();
        lo = 3'd1; hi = 3'd5; n_sweeps = 8'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (cif.cnt_q !== 3'd5 || cif.cnt_en !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL dwell_hi_reach cnt_q=%0d en=%b busy=%b exp 5 0 1", cif.cnt_q, cif.cnt_en, busy);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({busy, done, aborted, err, cif.cnt_en, cif.cnt_mode, cif.cnt_ld} !== 7'b0
            || cif.cnt_d !== 3'd0 || sweeps !== 8'd0) begin
            errors++;
            $display("FAIL async_reset flags=%b cnt_d=%0d sweeps=%0d exp 0",
                     {busy, done, aborted, err, cif.cnt_en, cif.cnt_mode, cif.cnt_ld}, cif.cnt_d, sweeps);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_free_run();
        int s_len;
        int done_seen;
        s_len = 2 * 2 + 2 * DWELL;
        lo = 3'd0; hi = 3'd1; n_sweeps = 8'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        done_seen = 0;
        for (int k = 1; k <= 257; k++) begin
            repeat (s_len) begin
                @(negedge clk);
                if (done === 1'b1) done_seen++;
            end
            checks++;
            if (sweeps !== 8'(k) || busy !== 1'b1) begin
                errors++;
                $display("FAIL free_run sweep %0d sweeps=%0d busy=%b exp %0d 1", k, sweeps, busy, 8'(k));
            end
        end
        checks++;
        if (done_seen !== 0) begin
            errors++;
            $display("FAIL free_run_done got=%0d exp=0", done_seen);
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        checks++;
        if (aborted !== 1'b1 || sweeps !== 8'd1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL free_run_stop aborted=%b sweeps=%0d busy=%b exp 1 1 0", aborted, sweeps, busy);
        end
        @(negedge clk);
    endtask

`ifdef SWEEP_CTRL_HOLD_EN
    task automatic test_hold();
        run_sweep(0, 5, 1, 4, 1'b0, "hold");
    endtask
`endif

    initial begin
        errors = 0; checks = 0;
        start = 1'b0; stop = 1'b0; hold = 1'b0;
        lo = '0; hi = '0; n_sweeps = '0;
        test_reset();
        test_single();
        test_multi();
        test_random();
        test_reject();
        test_abort();
        test_async_reset();
        test_free_run();
`ifdef SWEEP_CTRL_HOLD_EN
        test_hold();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
